// File: rtl/imem_pkg.sv
// ============================================================================
// imem_pkg : shared types and constants for the instruction-fetch responder
// Rev 1.0
// ============================================================================
`default_nettype none

package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic int idx_width(input int depth);
        return $clog2(depth);
    endfunction

    // Counter must hold LATENCY-1 and never be narrower than one bit.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// ============================================================================
// imem_array : DEPTH x 32 instruction storage, one sync write, one sync read
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_array #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [31:0]       i_wr_data,
    input  logic              i_rd_en,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [31:0]       o_rd_data
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rd_data;

    // Both ports use non-blocking updates, so a same-edge collision reads the old word.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/imem_responder.sv
// ============================================================================
// imem_responder : valid/ready instruction-fetch responder with fixed latency
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [63:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam int CNT_W = cnt_width(LATENCY);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [63:0]        r_addr;
    logic               r_err;

    logic               w_read;
    logic               w_err;
    logic [63:0]        w_rd_addr;
    logic [31:0]        w_rd_data;
    logic               w_ld_ok;
    logic               w_unused_ld;

    // With LATENCY=1 the read happens on the acceptance edge, so the live address is used.
    always_comb begin
        w_rd_addr = (r_state == IDLE) ? req_addr : r_addr;
        w_err     = (|w_rd_addr[1:0]) | (|w_rd_addr[63:IDX_W+2]);
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_read       = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        w_read       = 1'b1;
                        w_next_state = RESP;
                    end else begin
                        w_cnt_next   = CNT_W'(LATENCY - 1);
                        w_next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
                if (r_cnt <= CNT_W'(1)) begin
                    w_read       = 1'b1;
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (r_state == IDLE && req_valid) begin
                r_addr <= req_addr;
            end
            if (w_read) begin
                r_err <= w_err;
            end
        end
    end

    assign w_ld_ok     = ld_en & ~(|ld_addr[63:IDX_W+2]);
    assign w_unused_ld = ^ld_addr[1:0];

    imem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (w_ld_ok),
        .i_wr_idx  (ld_addr[IDX_W+1:2]),
        .i_wr_data (ld_data),
        .i_rd_en   (w_read & ~w_err),
        .i_rd_idx  (w_rd_addr[IDX_W+1:2]),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        req_ready = (r_state == IDLE) & ~reset;
        rsp_valid = (r_state == RESP);
        rsp_err   = rsp_valid & r_err;
        rsp_inst  = '0;
        if (rsp_valid) begin
            rsp_inst = r_err ? NOP_INST : w_rd_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
// ============================================================================
// tb_imem_responder : scoreboard bench for imem_responder (LATENCY 2 and 1)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_responder;

    localparam int LAT = 2;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ld_en;
    logic [63:0] req_addr, ld_addr;
    logic [31:0] rsp_inst, ld_data;

    logic        c_req_valid, c_req_ready, c_rsp_valid, c_rsp_ready, c_rsp_err, c_ld_en;
    logic [63:0] c_req_addr, c_ld_addr;
    logic [31:0] c_rsp_inst, c_ld_data;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   t_acc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_responder #(.DEPTH(64), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(c_req_valid), .req_ready(c_req_ready), .req_addr(c_req_addr),
        .rsp_valid(c_rsp_valid), .rsp_ready(c_rsp_ready), .rsp_inst(c_rsp_inst), .rsp_err(c_rsp_err),
        .ld_en(c_ld_en), .ld_addr(c_ld_addr), .ld_data(c_ld_data)
    );

    task automatic do_load(input logic [63:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic issue(input logic [63:0] a, output logic ok);
        ok = 1'b0;
        req_addr = a;
        req_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (req_ready) begin
                @(posedge clk); #1;
                t_acc = cyc;
                ok = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        req_valid = 1'b0;
    endtask

    // lat = edges from acceptance to the first edge that samples rsp_valid high.
    task automatic collect(input int hold, output logic [31:0] inst, output logic err,
                           output int lat, output logic stable, output logic rdy_after,
                           output logic ok);
        ok = 1'b0; stable = 1'b1; inst = '0; err = 1'b0; lat = -1; rdy_after = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (rsp_valid) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (ok) begin
            inst = rsp_inst;
            err  = rsp_err;
            lat  = cyc - t_acc + 1;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                if (rsp_valid !== 1'b1 || rsp_inst !== inst || rsp_err !== err || req_ready !== 1'b0)
                    stable = 1'b0;
            end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rdy_after = req_ready;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready_during got=%b want=0", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        reset = 1'b0;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready_after got=%b want=1", req_ready); end
        n_vec++; if (rsp_inst !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_inst got=%h want=0", rsp_inst); end
        n_vec++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
    endtask

    task automatic test_basic;
        exp_t e; logic ok, ok2, st, ra, err; logic [31:0] inst; int lat;
        rsp_ready = 1'b1;
        e = {32'h002081b3, 1'b0}; sb.push_back(e);
        issue(64'h8, ok);
        collect(0, inst, err, lat, st, ra, ok2);
        e = sb.pop_front();
        n_vec++; if (!(ok && ok2)) begin n_fail++; $display("FAIL basic_handshake got=%b%b want=11", ok, ok2); end
        n_vec++; if (lat !== LAT) begin n_fail++; $display("FAIL basic_latency got=%0d want=%0d", lat, LAT); end
        n_vec++; if (inst !== e.inst) begin n_fail++; $display("FAIL basic_inst got=%h want=%h", inst, e.inst); end
        n_vec++; if (err !== e.err) begin n_fail++; $display("FAIL basic_err got=%b want=%b", err, e.err); end
    endtask

    task automatic test_backpressure;
        exp_t e; logic ok, ok2, st, ra, err; logic [31:0] inst; int lat;
        rsp_ready = 1'b0;
        e = {32'h00a00113, 1'b0}; sb.push_back(e);
        issue(64'h4, ok);
        collect(5, inst, err, lat, st, ra, ok2);
        e = sb.pop_front();
        n_vec++; if (!(ok && ok2)) begin n_fail++; $display("FAIL bp_handshake got=%b%b want=11", ok, ok2); end
        n_vec++; if (inst !== e.inst) begin n_fail++; $display("FAIL bp_inst got=%h want=%h", inst, e.inst); end
        n_vec++; if (st !== 1'b1) begin n_fail++; $display("FAIL bp_stable got=%b want=1", st); end
        n_vec++; if (ra !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after got=%b want=1", ra); end
    endtask

    task automatic test_errors;
        logic [63:0] addrs [5];
        exp_t exps [5];
        exp_t e; logic ok, ok2, st, ra, err; logic [31:0] inst; int lat;
        addrs[0] = 64'h6;            exps[0] = {32'h00000013, 1'b1};
        addrs[1] = 64'h100;          exps[1] = {32'h00000013, 1'b1};
        addrs[2] = 64'hFC;           exps[2] = {32'h12345678, 1'b0};
        addrs[3] = 64'h100_0000_0000; exps[3] = {32'h00000013, 1'b1};
        addrs[4] = 64'h0;            exps[4] = {32'h00500093, 1'b0};
        do_load(64'hFC, 32'h12345678);
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(exps[i]);
            issue(addrs[i], ok);
            collect(0, inst, err, lat, st, ra, ok2);
            e = sb.pop_front();
            n_vec++; if (!(ok && ok2) || inst !== e.inst || err !== e.err) begin
                n_fail++;
                $display("FAIL err_case%0d addr=%h got inst=%h err=%b want inst=%h err=%b", i, addrs[i], inst, err, e.inst, e.err);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic ok, seen;
        rsp_ready = 1'b1;
        issue(64'h0, ok);
        reset = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (rsp_valid !== 1'b0 || rsp_inst !== 32'h0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs got v=%b i=%h e=%b r=%b want 0 0 0 0", rsp_valid, rsp_inst, rsp_err, req_ready);
        end
        reset = 1'b0;
        seen = 1'b0;
        repeat (LAT + 3) begin
            #1; if (rsp_valid) seen = 1'b1;
            @(posedge clk);
        end
        #1;
        n_vec++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_rsp got=%b want=0", seen); end
        n_vec++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_back_to_back;
        exp_t e; logic ok, ok2, st, ra, err; logic [31:0] inst; int lat, prev;
        logic [31:0] prog [4];
        prog[0] = 32'h00500093; prog[1] = 32'h00a00113;
        prog[2] = 32'h002081b3; prog[3] = 32'h00000013;
        rsp_ready = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            e = {prog[i], 1'b0}; sb.push_back(e);
            issue(64'(4 * i), ok);
            collect(0, inst, err, lat, st, ra, ok2);
            e = sb.pop_front();
            n_vec++; if (!(ok && ok2) || inst !== e.inst || err !== e.err) begin
                n_fail++; $display("FAIL b2b_data%0d got=%h/%b want=%h/%b", i, inst, err, e.inst, e.err);
            end
            if (i > 0) begin
                n_vec++; if (t_acc - prev !== LAT + 1) begin
                    n_fail++; $display("FAIL b2b_spacing%0d got=%0d want=%0d", i, t_acc - prev, LAT + 1);
                end
            end
            prev = t_acc;
        end
    endtask

    task automatic test_collision;
        exp_t e;
        c_ld_en = 1'b1; c_ld_addr = 64'h0; c_ld_data = 32'h00500093;
        @(posedge clk); #1;
        c_ld_en = 1'b0;
        c_rsp_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e = {(k == 0) ? 32'h00500093 : 32'hdeadbeef, 1'b0};
            sb.push_back(e);
            c_req_addr = 64'h0; c_req_valid = 1'b1;
            if (k == 0) begin c_ld_en = 1'b1; c_ld_addr = 64'h0; c_ld_data = 32'hdeadbeef; end
            n_vec++; if (c_req_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready%0d got=%b want=1", k, c_req_ready); end
            @(posedge clk); #1;
            c_req_valid = 1'b0; c_ld_en = 1'b0;
            e = sb.pop_front();
            n_vec++; if (c_rsp_valid !== 1'b1 || c_rsp_inst !== e.inst || c_rsp_err !== e.err) begin
                n_fail++;
                $display("FAIL coll_rsp%0d got v=%b i=%h e=%b want v=1 i=%h e=%b", k, c_rsp_valid, c_rsp_inst, c_rsp_err, e.inst, e.err);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        c_req_valid = 1'b0; c_rsp_ready = 1'b0; c_req_addr = '0;
        c_ld_en = 1'b0; c_ld_addr = '0; c_ld_data = '0;
        test_reset();
        do_load(64'h0, 32'h00500093);
        do_load(64'h4, 32'h00a00113);
        do_load(64'h8, 32'h002081b3);
        do_load(64'hC, 32'h00000013);
        do_load(64'h100, 32'hffffffff);
        test_basic();
        test_backpressure();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        test_collision();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
